// File: rtl/sb_tx_scheduler_if.sv
// Handshake bundle between the sideband TX requesters, the TX frame builder and
// sb_tx_scheduler. The scheduler is the slave; requesters and builder form the master.
interface sb_tx_scheduler_if;
    logic       disconnect;
    logic       lt_req;
    logic       at_rsp_req;
    logic       at_cmd_req;
    logic       lt_gnt;
    logic       at_rsp_gnt;
    logic       at_cmd_gnt;
    logic       tx_start;
    logic [1:0] tx_sel;
    logic       tx_done;
    logic       rsp_valid;
    logic       at_cmd_done;
    logic       at_cmd_fail;
    logic [1:0] retry_cnt;
    logic       busy;

    modport master (
        output disconnect, lt_req, at_rsp_req, at_cmd_req, tx_done, rsp_valid,
        input  lt_gnt, at_rsp_gnt, at_cmd_gnt, tx_start, tx_sel,
        input  at_cmd_done, at_cmd_fail, retry_cnt, busy
    );

    modport slave (
        input  disconnect, lt_req, at_rsp_req, at_cmd_req, tx_done, rsp_valid,
        output lt_gnt, at_rsp_gnt, at_cmd_gnt, tx_start, tx_sel,
        output at_cmd_done, at_cmd_fail, retry_cnt, busy
    );
endinterface

// File: rtl/sb_tx_scheduler.sv
// Fixed-priority (LT > AT rsp > AT cmd) arbiter for the sideband TX frame builder,
// plus a tracker for the single outstanding AT command with timeout and bounded resend.
module sb_tx_scheduler #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd1000,
    parameter logic [1:0]  MAX_RETRY   = 2'd2
) (
    input logic              sb_clk,
    input logic              rst,
    sb_tx_scheduler_if.slave bus
);

    typedef enum logic {StIdle, StSend} state_e;
    typedef enum logic [1:0] {CIdle, CWait, CRetry} trk_e;

    localparam logic [1:0] SelNone = 2'b00;
    localparam logic [1:0] SelLt   = 2'b01;
    localparam logic [1:0] SelRsp  = 2'b10;
    localparam logic [1:0] SelCmd  = 2'b11;

    state_e      state_q;
    trk_e        trk_q;
    logic [15:0] timer_q;
    logic [1:0]  sel_q;
    logic [2:0]  gnt_q;
    logic [1:0]  retry_q;
    logic        start_q;
    logic        done_q;
    logic        fail_q;

    logic req_lt;
    logic req_rsp;
    logic req_cmd;
    logic cmd_sent;

    // A new command is only accepted when nothing is outstanding; a pending resend
    // requests the builder on its own.
    assign req_lt   = bus.lt_req;
    assign req_rsp  = bus.at_rsp_req;
    assign req_cmd  = (bus.at_cmd_req && (trk_q == CIdle)) || (trk_q == CRetry);
    assign cmd_sent = (state_q == StSend) && bus.tx_done && (sel_q == SelCmd);

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            trk_q   <= CIdle;
            timer_q <= '0;
            sel_q   <= SelNone;
            gnt_q   <= '0;
            retry_q <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else if (bus.disconnect) begin
            state_q <= StIdle;
            trk_q   <= CIdle;
            timer_q <= '0;
            sel_q   <= SelNone;
            gnt_q   <= '0;
            retry_q <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (req_lt || req_rsp || req_cmd) begin
                        state_q <= StSend;
                        start_q <= 1'b1;
                        if (req_lt) begin
                            sel_q <= SelLt;
                            gnt_q <= 3'b001;
                        end else if (req_rsp) begin
                            sel_q <= SelRsp;
                            gnt_q <= 3'b010;
                        end else begin
                            sel_q <= SelCmd;
                            gnt_q <= 3'b100;
                        end
                    end
                end
                StSend: begin
                    if (bus.tx_done) begin
                        state_q <= StIdle;
                        sel_q   <= SelNone;
                        gnt_q   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase

            case (trk_q)
                CIdle, CRetry: begin
                    if (cmd_sent) begin
                        trk_q   <= CWait;
                        timer_q <= '0;
                    end
                end
                CWait: begin
                    // A response arriving on the expiry cycle still counts as an answer.
                    if (bus.rsp_valid) begin
                        done_q  <= 1'b1;
                        retry_q <= '0;
                        trk_q   <= CIdle;
                        timer_q <= '0;
                    end else if (timer_q == TIMEOUT_CYC - 16'd1) begin
                        timer_q <= '0;
                        if (retry_q == MAX_RETRY) begin
                            fail_q  <= 1'b1;
                            retry_q <= '0;
                            trk_q   <= CIdle;
                        end else begin
                            retry_q <= retry_q + 2'd1;
                            trk_q   <= CRetry;
                        end
                    end else if (timer_q != 16'hFFFF) begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: trk_q <= CIdle;
            endcase
        end
    end

    assign bus.lt_gnt      = gnt_q[0];
    assign bus.at_rsp_gnt  = gnt_q[1];
    assign bus.at_cmd_gnt  = gnt_q[2];
    assign bus.tx_sel      = sel_q;
    assign bus.tx_start    = start_q;
    assign bus.at_cmd_done = done_q;
    assign bus.at_cmd_fail = fail_q;
    assign bus.retry_cnt   = retry_q;
    assign bus.busy        = (state_q != StIdle) || (trk_q != CIdle);

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// Bench for sb_tx_scheduler: a frame-builder model answers tx_start with tx_done, and
// expected frame selections are queued as stimulus is applied and popped per frame.
module tb_sb_tx_scheduler;

    localparam int TO        = 8;
    localparam int FRAME_LEN = 3;
    localparam int GAP       = FRAME_LEN + 3;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
        logic [2:0] gnt;
        logic [1:0] rc;
    } start_t;

    logic sb_clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   fcnt;

    start_t     starts[$];
    logic [1:0] exp_sel[$];
    logic [1:0] exp_rc[$];
    int         done_cycs[$];
    int         cmd_done_cycs[$];
    int         fail_cycs[$];

    sb_tx_scheduler_if bus ();

    sb_tx_scheduler #(
        .TIMEOUT_CYC(16'd8),
        .MAX_RETRY  (2'd2)
    ) dut (
        .sb_clk(sb_clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 sb_clk = ~sb_clk;

    // Frame builder: tx_done is visible FRAME_LEN+1 cycles after the tx_start cycle.
    always @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            fcnt        <= 0;
            bus.tx_done <= 1'b0;
        end else begin
            bus.tx_done <= 1'b0;
            if (bus.disconnect) fcnt <= 0;
            else if (bus.tx_start) fcnt <= FRAME_LEN;
            else if (fcnt == 1) begin
                fcnt        <= 0;
                bus.tx_done <= 1'b1;
            end else if (fcnt > 1) fcnt <= fcnt - 1;
        end
    end

    function automatic logic [2:0] sel_to_gnt(logic [1:0] s);
        case (s)
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic tick();
        @(negedge sb_clk);
        cyc++;
        if (bus.tx_start)
            starts.push_back('{cyc, bus.tx_sel,
                               {bus.at_cmd_gnt, bus.at_rsp_gnt, bus.lt_gnt}, bus.retry_cnt});
        if (bus.tx_done) done_cycs.push_back(cyc);
        if (bus.at_cmd_done) cmd_done_cycs.push_back(cyc);
        if (bus.at_cmd_fail) fail_cycs.push_back(cyc);
        if (bus.lt_gnt) bus.lt_req = 1'b0;
        if (bus.at_rsp_gnt) bus.at_rsp_req = 1'b0;
        if (bus.at_cmd_gnt) bus.at_cmd_req = 1'b0;
    endtask

    task automatic tick_n(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        starts.delete();
        exp_sel.delete();
        exp_rc.delete();
        done_cycs.delete();
        cmd_done_cycs.delete();
        fail_cycs.delete();
    endtask

    task automatic wait_done(int n, string name);
        for (int i = 0; i < 200 && done_cycs.size() < n; i++) tick();
        n_checks++;
        if (done_cycs.size() < n) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d tx_done want %0d", name, done_cycs.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.disconnect = 1'b0;
        bus.lt_req = 1'b0;
        bus.at_rsp_req = 1'b0;
        bus.at_cmd_req = 1'b0;
        bus.rsp_valid = 1'b0;
        #3;
        n_checks++;
        if ({bus.at_cmd_gnt, bus.at_rsp_gnt, bus.lt_gnt} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b want 000",
                     {bus.at_cmd_gnt, bus.at_rsp_gnt, bus.lt_gnt});
        end
        n_checks++;
        if ({bus.tx_start, bus.tx_sel, bus.at_cmd_done, bus.at_cmd_fail} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b want 00000",
                     {bus.tx_start, bus.tx_sel, bus.at_cmd_done, bus.at_cmd_fail});
        end
        n_checks++;
        if ({bus.retry_cnt, bus.busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_cnt_busy: got %b want 000", {bus.retry_cnt, bus.busy});
        end
        @(negedge sb_clk);
        rst = 1'b1;
        tick_n(2);
    endtask

    task automatic test_priority();
        start_t s;
        logic [1:0] e;
        clear_logs();
        exp_sel.push_back(2'b01);
        exp_sel.push_back(2'b10);
        exp_sel.push_back(2'b11);
        bus.lt_req = 1'b1;
        bus.at_rsp_req = 1'b1;
        bus.at_cmd_req = 1'b1;
        wait_done(3, "prio");
        tick_n(2);
        n_checks++;
        if (starts.size() != 3) begin
            n_fail++;
            $display("FAIL prio_nstart: got %0d want 3", starts.size());
        end
        n_checks++;
        if (starts.size() >= 3 && (starts[1].cyc - starts[0].cyc != GAP
                                   || starts[2].cyc - starts[1].cyc != GAP)) begin
            n_fail++;
            $display("FAIL prio_gap: got %0d,%0d want %0d", starts[1].cyc - starts[0].cyc,
                     starts[2].cyc - starts[1].cyc, GAP);
        end
        while (exp_sel.size() > 0 && starts.size() > 0) begin
            s = starts.pop_front();
            e = exp_sel.pop_front();
            n_checks++;
            if (s.sel !== e || s.gnt !== sel_to_gnt(e)) begin
                n_fail++;
                $display("FAIL prio_frame: got sel %b gnt %b want sel %b gnt %b",
                         s.sel, s.gnt, e, sel_to_gnt(e));
            end
        end
        bus.rsp_valid = 1'b1;
        tick();
        bus.rsp_valid = 1'b0;
        tick();
        n_checks++;
        if (cmd_done_cycs.size() != 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_cleanup: got done %0d busy %b want 1 0",
                     cmd_done_cycs.size(), bus.busy);
        end
    endtask

    task automatic test_cmd_done();
        int c;
        int dc;
        start_t s;
        clear_logs();
        exp_sel.push_back(2'b11);
        bus.at_cmd_req = 1'b1;
        wait_done(1, "done");
        c = (done_cycs.size() > 0) ? done_cycs[0] : cyc;
        while (cyc < c + 5) tick();
        bus.rsp_valid = 1'b1;
        tick();
        bus.rsp_valid = 1'b0;
        tick_n(TO + 4);
        dc = (cmd_done_cycs.size() > 0) ? cmd_done_cycs[0] : -1;
        n_checks++;
        if (cmd_done_cycs.size() != 1 || dc != c + 6) begin
            n_fail++;
            $display("FAIL done_pulse: got n=%0d at %0d want n=1 at %0d",
                     cmd_done_cycs.size(), dc, c + 6);
        end
        n_checks++;
        if (fail_cycs.size() != 0 || starts.size() != 1) begin
            n_fail++;
            $display("FAIL done_no_retry: got fail %0d starts %0d want 0 1",
                     fail_cycs.size(), starts.size());
        end
        n_checks++;
        if (bus.retry_cnt !== 2'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_idle: got rc %0d busy %b want 0 0", bus.retry_cnt, bus.busy);
        end
        if (starts.size() > 0) begin
            s = starts.pop_front();
            n_checks++;
            if (s.sel !== exp_sel.pop_front()) begin
                n_fail++;
                $display("FAIL done_sel: got %b want 11", s.sel);
            end
        end
    endtask

    task automatic test_retry_fail();
        int fc;
        int last;
        start_t s;
        logic [1:0] e;
        logic [1:0] r;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            exp_sel.push_back(2'b11);
            exp_rc.push_back(2'(i));
        end
        bus.at_cmd_req = 1'b1;
        for (int i = 0; i < 200 && fail_cycs.size() == 0; i++) tick();
        tick_n(TO + 4);
        fc = (fail_cycs.size() > 0) ? fail_cycs[0] : -1;
        last = (done_cycs.size() > 2) ? done_cycs[2] : -100;
        n_checks++;
        if (starts.size() != 3) begin
            n_fail++;
            $display("FAIL retry_nstart: got %0d want 3", starts.size());
        end
        n_checks++;
        if (fail_cycs.size() != 1 || fc != last + TO + 1) begin
            n_fail++;
            $display("FAIL retry_fail_pulse: got n=%0d at %0d want n=1 at %0d",
                     fail_cycs.size(), fc, last + TO + 1);
        end
        n_checks++;
        if (cmd_done_cycs.size() != 0 || bus.retry_cnt !== 2'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL retry_after: got done %0d rc %0d busy %b want 0 0 0",
                     cmd_done_cycs.size(), bus.retry_cnt, bus.busy);
        end
        while (exp_sel.size() > 0 && starts.size() > 0) begin
            s = starts.pop_front();
            e = exp_sel.pop_front();
            r = exp_rc.pop_front();
            n_checks++;
            if (s.sel !== e || s.rc !== r) begin
                n_fail++;
                $display("FAIL retry_frame: got sel %b rc %0d want sel %b rc %0d",
                         s.sel, s.rc, e, r);
            end
        end
    endtask

    task automatic test_wait_traffic();
        int c;
        clear_logs();
        bus.at_cmd_req = 1'b1;
        wait_done(1, "wait");
        c = (done_cycs.size() > 0) ? done_cycs[0] : cyc;
        tick();
        bus.at_rsp_req = 1'b1;
        bus.at_cmd_req = 1'b1;
        for (int i = 0; i < 60 && starts.size() < 3; i++) tick();
        n_checks++;
        if (starts.size() != 3) begin
            n_fail++;
            $display("FAIL wait_nstart: got %0d want 3", starts.size());
        end else begin
            n_checks++;
            if (starts[1].sel !== 2'b10 || starts[1].gnt !== 3'b010 || starts[1].cyc != c + 2)
            begin
                n_fail++;
                $display("FAIL wait_rsp_frame: got sel %b gnt %b cyc %0d want 10 010 %0d",
                         starts[1].sel, starts[1].gnt, starts[1].cyc, c + 2);
            end
            n_checks++;
            if (starts[2].sel !== 2'b11 || starts[2].rc !== 2'd1 || starts[2].cyc != c + TO + 2)
            begin
                n_fail++;
                $display("FAIL wait_resend: got sel %b rc %0d cyc %0d want 11 1 %0d",
                         starts[2].sel, starts[2].rc, starts[2].cyc, c + TO + 2);
            end
        end
        wait_done(3, "wait_resend");
        tick_n(2);
        bus.rsp_valid = 1'b1;
        tick();
        bus.rsp_valid = 1'b0;
        tick();
        n_checks++;
        if (cmd_done_cycs.size() != 1 || bus.busy !== 1'b0 || bus.retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL wait_end: got done %0d busy %b rc %0d want 1 0 0",
                     cmd_done_cycs.size(), bus.busy, bus.retry_cnt);
        end
    endtask

    task automatic test_same_cycle();
        int c;
        int dc;
        clear_logs();
        bus.at_cmd_req = 1'b1;
        wait_done(1, "same");
        c = (done_cycs.size() > 0) ? done_cycs[0] : cyc;
        while (cyc < c + TO) tick();
        bus.rsp_valid = 1'b1;
        tick();
        bus.rsp_valid = 1'b0;
        tick_n(TO + 4);
        dc = (cmd_done_cycs.size() > 0) ? cmd_done_cycs[0] : -1;
        n_checks++;
        if (cmd_done_cycs.size() != 1 || dc != c + TO + 1) begin
            n_fail++;
            $display("FAIL same_done: got n=%0d at %0d want n=1 at %0d",
                     cmd_done_cycs.size(), dc, c + TO + 1);
        end
        n_checks++;
        if (fail_cycs.size() != 0 || starts.size() != 1 || bus.retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL same_no_resend: got fail %0d starts %0d rc %0d want 0 1 0",
                     fail_cycs.size(), starts.size(), bus.retry_cnt);
        end
    endtask

    task automatic test_disconnect();
        start_t s;
        logic [1:0] e;
        clear_logs();
        exp_sel.push_back(2'b11);
        exp_sel.push_back(2'b01);
        bus.at_cmd_req = 1'b1;
        for (int i = 0; i < 20 && starts.size() < 1; i++) tick();
        tick();
        bus.disconnect = 1'b1;
        bus.lt_req = 1'b1;
        tick();
        n_checks++;
        if ({bus.at_cmd_gnt, bus.at_rsp_gnt, bus.lt_gnt, bus.tx_sel, bus.tx_start} !== 6'b0) begin
            n_fail++;
            $display("FAIL disc_flush: got %b want 000000",
                     {bus.at_cmd_gnt, bus.at_rsp_gnt, bus.lt_gnt, bus.tx_sel, bus.tx_start});
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL disc_busy: got busy %b rc %0d want 0 0", bus.busy, bus.retry_cnt);
        end
        tick_n(3);
        n_checks++;
        if (starts.size() != 1 || bus.lt_gnt !== 1'b0 || cmd_done_cycs.size() != 0
            || fail_cycs.size() != 0) begin
            n_fail++;
            $display("FAIL disc_hold: got starts %0d lt_gnt %b done %0d fail %0d want 1 0 0 0",
                     starts.size(), bus.lt_gnt, cmd_done_cycs.size(), fail_cycs.size());
        end
        bus.disconnect = 1'b0;
        for (int i = 0; i < 20 && starts.size() < 2; i++) tick();
        tick_n(GAP);
        while (exp_sel.size() > 0 && starts.size() > 0) begin
            s = starts.pop_front();
            e = exp_sel.pop_front();
            n_checks++;
            if (s.sel !== e) begin
                n_fail++;
                $display("FAIL disc_frame: got %b want %b", s.sel, e);
            end
        end
        n_checks++;
        if (exp_sel.size() != 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL disc_end: got missing %0d busy %b want 0 0", exp_sel.size(), bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        bus.lt_req = 1'b1;
        for (int i = 0; i < 20 && starts.size() < 1; i++) tick();
        tick();
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.at_cmd_gnt, bus.at_rsp_gnt, bus.lt_gnt, bus.tx_sel, bus.tx_start,
             bus.at_cmd_done, bus.at_cmd_fail, bus.retry_cnt, bus.busy} !== 11'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got %b want all zero",
                     {bus.at_cmd_gnt, bus.at_rsp_gnt, bus.lt_gnt, bus.tx_sel, bus.tx_start,
                      bus.at_cmd_done, bus.at_cmd_fail, bus.retry_cnt, bus.busy});
        end
        @(negedge sb_clk);
        rst = 1'b1;
        tick_n(3);
        n_checks++;
        if (starts.size() != 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got starts %0d busy %b want 1 0",
                     starts.size(), bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_cmd_done();
        test_retry_fail();
        test_wait_traffic();
        test_same_cycle();
        test_disconnect();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
